// File: rtl/load_unit.sv
// load_unit: memory load engine, runs a req/ack/valid read and returns the word
// Ports:
//    clk, rst_n          clock (rising edge), synchronous active-low reset
//    ld_start, ld_addr   load command and address, taken only when idle
//    busy                high whenever a load is in progress
//    mem_rd_req          read request to data memory (REQ state)
//    mem_addr            address of the last accepted load
//    mem_rd_ack          memory accepted the request
//    mem_rd_valid        read data valid
//    mem_rd_data         read data
//    loaded_data         last successfully loaded word
//    ld_done             one-cycle completion pulse
//    ld_err              one-cycle abort flag alongside ld_done
// Optional feature: define LOAD_TIMEOUT_EN to abort loads stuck for TIMEOUT cycles.
module load_unit #(
   parameter int DATA_W  = 20,
   parameter int ADDR_W  = 20,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ld_start,
   input  logic [ADDR_W-1:0] ld_addr,
   output logic              busy,
   output logic              mem_rd_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_rd_ack,
   input  logic              mem_rd_valid,
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic [DATA_W-1:0] loaded_data,
   output logic              ld_done,
   output logic              ld_err
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   state_t state, state_nxt;
   logic   complete;
   logic   expire;
   logic   err_q;

   // data arrives this cycle: ack+valid together in REQ, or valid in WAIT
   assign complete = (state == REQ && mem_rd_ack && mem_rd_valid) ||
                     (state == WAIT && mem_rd_valid);

`ifdef LOAD_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT);

   logic [CW-1:0] cnt;

   // counter sits at 0 outside REQ/WAIT, so it starts from 0 on entry to REQ
   always_ff @(posedge clk) begin
      if (!rst_n)
         cnt <= '0;
      else
         cnt <= (state == REQ || state == WAIT) ? cnt + 1'b1 : '0;
   end

   // a load completing in the expiry cycle wins over the abort
   assign expire = (state == REQ || state == WAIT) && cnt == CW'(TIMEOUT - 1) && !complete;
`else
   // no timeout: wait indefinitely; TIMEOUT kept referenced so both builds share one parameter list
   assign expire = 1'b0 & (TIMEOUT >= 2);
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         mem_addr    <= '0;
         loaded_data <= '0;
         err_q       <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && ld_start)
            mem_addr <= ld_addr;
         if (complete)
            loaded_data <= mem_rd_data;
         err_q <= expire;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = ld_start ? REQ : IDLE;
         REQ:     state_nxt = (complete || expire) ? DONE : (mem_rd_ack ? WAIT : REQ);
         WAIT:    state_nxt = (complete || expire) ? DONE : WAIT;
         default: state_nxt = IDLE;
      endcase
   end

   // outputs decode the state register only, so they are glitch-free and registered
   always_comb begin
      busy       = state != IDLE;
      mem_rd_req = state == REQ;
      ld_done    = state == DONE;
      ld_err     = state == DONE && err_q;
   end

endmodule

// File: doc/load_unit.md
# load_unit

Memory load engine for the UrCPU datapath; the read-side counterpart of the STD store path. Accepts a load command with a 20-bit address, runs a request/acknowledge/valid read transaction against data memory, and returns the loaded word to the register-file write port with a one-cycle completion pulse. Sits between the ALU/memory decode stage and the data-memory port.

## Interface
- DATA_W, 20, width of loaded word
- ADDR_W, 20, width of memory address
- TIMEOUT, 16, max cycles in REQ+WAIT before abort (used only with LOAD_TIMEOUT_EN; must be ≥ 2)

- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- ld_start  in  1  load command; sampled only in IDLE
- ld_addr  in  ADDR_W  load address, sampled with ld_start
- busy  out  1  high in every state except IDLE
- mem_rd_req  out  1  read request to memory
- mem_addr  out  ADDR_W  latched load address
- mem_rd_ack  in  1  memory accepted request
- mem_rd_valid  in  1  read data valid
- mem_rd_data  in  DATA_W  read data
- loaded_data  out  DATA_W  last successfully loaded word (registered)
- ld_done  out  1  one-cycle completion pulse
- ld_err  out  1  one-cycle abort flag, coincident with ld_done (constant 0 without LOAD_TIMEOUT_EN)

## Operation
- States: IDLE, REQ, WAIT, DONE; 2-bit encoded register.
- IDLE: ld_start=1 → latch ld_addr into mem_addr, go REQ. ld_start ignored in all other states (no queuing).
- REQ: mem_rd_req=1. mem_rd_ack=1 & mem_rd_valid=0 → WAIT. mem_rd_ack=1 & mem_rd_valid=1 → latch mem_rd_data, go DONE. Otherwise stay.
- WAIT: mem_rd_req=0. mem_rd_valid=1 → latch mem_rd_data into loaded_data, go DONE.
- DONE: ld_done=1 for exactly this cycle, then IDLE.
- mem_rd_valid outside REQ/WAIT ignored; mem_rd_ack outside REQ ignored.
- mem_addr holds its value until next accepted ld_start.
- loaded_data changes only on a successful load; holds otherwise, including across aborts.

## Timing
- Reset (rst_n=0 at edge): state=IDLE, busy=0, mem_rd_req=0, mem_addr=0, loaded_data=0, ld_done=0, ld_err=0, timeout counter=0.
- Reset mid-transaction abandons it: mem_rd_req low the cycle after the reset edge; no ld_done.
- ld_start accepted at edge N → mem_rd_req high from cycle N+1.
- Minimum latency (ack and valid both in first REQ cycle): ld_done in cycle N+2, loaded_data valid same cycle.
- Typical (ack in N+1, valid in N+2): ld_done in N+3.
- busy drops in the cycle after DONE; new ld_start accepted then (back-to-back period ≥ 3 cycles).
- All outputs registered; no combinational input→output paths.

## Configuration
- LOAD_TIMEOUT_EN defined: counter of width $clog2(TIMEOUT) cleared on entry to REQ, increments each cycle in REQ/WAIT. If counter reaches TIMEOUT-1 and the current cycle does not complete the load, go DONE with ld_done=1 and ld_err=1, mem_rd_req dropped, loaded_data unchanged. Completion in the same cycle as expiry wins (ld_err=0).
- Not defined: no counter; FSM waits indefinitely in REQ/WAIT; ld_err tied 0.

## Test plan
- Reset: hold rst_n=0 two cycles with ld_start=1 → all outputs 0, state IDLE, no mem_rd_req.
- Fast load: ld_start, ld_addr=20'h00ABC; ack+valid with mem_rd_data=20'h12345 in first REQ cycle → mem_addr=20'h00ABC, ld_done at N+2, loaded_data=20'h12345.
- Delayed load: ack after 3 REQ cycles, valid 2 cycles later, data=20'hFFFFF → mem_rd_req high exactly 4 cycles, ld_done once, loaded_data=20'hFFFFF, ld_err=0.
- Busy ignore: second ld_start with ld_addr=20'h00001 while in WAIT → mem_addr stays 20'h00ABC, single ld_done.
- Reset mid-operation: rst_n=0 in WAIT → next cycle busy=0, mem_rd_req=0, loaded_data=0, no ld_done; later valid ignored.
- LOAD_TIMEOUT_EN, TIMEOUT=16: ack but never valid → ld_done=ld_err=1 exactly 16 cycles after entering REQ, loaded_data holds previous value; valid on cycle 16 → ld_err=0, data latched.
